// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths, constants and FSM state type for the FP normalize/pack path
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      FP_ZERO = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } fp_state_t;

endpackage

// File: rtl/fp_pack.sv
// rtl/fp_pack.sv - combinational IEEE-754 single packer with infinity/zero override
module fp_pack
  import fp_pkg::*;
(
  input  logic             signIn,
  input  logic [EXP_W-1:0] expIn,
  input  logic [MAN_W-1:0] fracIn,
  input  logic             forceInf,
  input  logic             forceZero,
  output logic [31:0]      result
);

  // Zero override wins over infinity; zero also drops the sign.
  always_comb begin
    result = {signIn, expIn, fracIn};
    if (forceZero) begin
      result = FP_ZERO;
    end else if (forceInf) begin
      result = {signIn, EXP_MAX, {MAN_W{1'b0}}};
    end
  end

endmodule

// File: rtl/fp_normalize_pack.sv
// rtl/fp_normalize_pack.sv - normalizes an add/sub mantissa sum and packs it as IEEE-754 single
module fp_normalize_pack
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_man,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_ovf,
  output logic        out_unf
);

  fp_state_t state;
  fp_state_t stateNext;

  // Working operand; exponent carries a ninth bit so carry/decrement never wraps.
  logic        signR;
  logic [8:0]  expR;
  logic [24:0] manR;

  // First NORM cycle is the prep step: zero detection and carry right-shift.
  logic        firstCycle;
  logic        zeroFlag;
  logic        ovfFlag;

  logic [31:0] resultR;
  logic        ovfR;
  logic        unfR;

  logic [8:0]  expPlus;
  logic        doShift;
  logic        finishing;
  logic        finishOvf;
  logic        finishUnf;
  logic [31:0] packedWord;

  assign expPlus = expR + 9'd1;

  // Decision order after prep: zero, carry overflow, normalized, underflow, else shift left.
  always_comb begin
    finishOvf = !firstCycle && !zeroFlag && ovfFlag;
    finishUnf = !firstCycle && !zeroFlag && !ovfFlag && !manR[23] && (expR <= 9'd1);
    doShift   = !firstCycle && !zeroFlag && !ovfFlag && !manR[23] && (expR > 9'd1);
    finishing = !firstCycle && !doShift;
  end

  fp_pack uPack (
    .signIn    (signR),
    .expIn     (expR[EXP_W-1:0]),
    .fracIn    (manR[MAN_W-1:0]),
    .forceInf  (finishOvf),
    .forceZero (zeroFlag || finishUnf),
    .result    (packedWord)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (in_valid) stateNext = NORM;
      NORM:    if (finishing) stateNext = DONE;
      DONE:    if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: capture, prep, shift-left normalization and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signR      <= 1'b0;
      expR       <= '0;
      manR       <= '0;
      firstCycle <= 1'b0;
      zeroFlag   <= 1'b0;
      ovfFlag    <= 1'b0;
      resultR    <= FP_ZERO;
      ovfR       <= 1'b0;
      unfR       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            signR      <= in_sign;
            expR       <= {1'b0, in_exp};
            manR       <= in_man;
            firstCycle <= 1'b1;
            zeroFlag   <= 1'b0;
            ovfFlag    <= 1'b0;
          end
        end
        NORM: begin
          if (firstCycle) begin
            firstCycle <= 1'b0;
            zeroFlag   <= (manR == 25'd0) || (expR == 9'd0);
            if (manR[24]) begin
              manR    <= manR >> 1;
              expR    <= expPlus;
              ovfFlag <= (expPlus >= 9'd255);
            end
          end else if (doShift) begin
            manR <= manR << 1;
            expR <= expR - 9'd1;
          end else begin
            resultR <= packedWord;
            ovfR    <= finishOvf;
            unfR    <= finishUnf;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_result = resultR;
  assign out_ovf    = ovfR;
  assign out_unf    = unfR;

endmodule

// File: doc/fp_normalize_pack.md
FP_NORMALIZE_PACK -- requirements
Module: fp_normalize_pack

Interface
REQ-001 clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  upstream presents an unnormalized add/sub result.
REQ-004 in_ready  output  1  block accepts input; transfer occurs on in_valid && in_ready at a clock edge.
REQ-005 in_sign  input  1  result sign.
REQ-006 in_exp  input  8  biased exponent of the larger operand.
REQ-007 in_man  input  25  raw mantissa sum; bit 24 = carry-out, bit 23 = hidden-bit position.
REQ-008 out_valid  output  1  out_result is valid.
REQ-009 out_ready  input  1  downstream accepts; transfer occurs on out_valid && out_ready at a clock edge.
REQ-010 out_result  output  32  packed IEEE-754 single: {sign, exp[7:0], frac[22:0]}.
REQ-011 out_ovf  output  1  result saturated to infinity; valid with out_valid.
REQ-012 out_unf  output  1  result flushed to zero because the exponent underflowed; valid with out_valid.

Function
REQ-013 The FSM SHALL have three states: IDLE, NORM and DONE.
REQ-014 In IDLE: in_ready=1; on accept, register in_sign, in_exp and in_man, then go to NORM.
REQ-015 In NORM and DONE: in_ready=0.
REQ-016 Zero input: if man==0 or exp==0, out_result=32'h0000_0000 (sign cleared), both flags 0, go to DONE.
REQ-017 Carry (man[24]=1): man>>=1 with the dropped bit truncated (no rounding), exp+=1; go to DONE.
REQ-018 Carry overflow: if exp+1 >= 255, out_result={sign,8'hFF,23'h0}, out_ovf=1, go to DONE.
REQ-019 Normalized (man[24:23]=2'b01): pack {sign, exp, man[22:0]}; go to DONE.
REQ-020 Left normalization (man[24:23]=2'b00, man!=0): exp>1 -> man<<=1, exp-=1, stay in NORM; one bit per cycle.
REQ-021 Underflow: if man[24:23]=2'b00 and exp<=1, out_result=32'h0000_0000 and out_unf=1, go to DONE.
REQ-022 Exponent arithmetic SHALL use 9 bits internally so that no wrap-around occurs.
REQ-023 In DONE: out_valid=1; out_result and flags held stable until out_ready=1, then go to IDLE.
REQ-024 No new input is accepted in the cycle the output is consumed; accept is possible from the next cycle.
REQ-025 Latency: accept edge to out_valid = 2+k cycles, where k = left shifts performed (0..23).
REQ-026 Maximum latency = 25 cycles.
REQ-027 out_valid SHALL be 0 in IDLE and NORM.
REQ-028 Flags are mutually exclusive.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, out_valid=0, in_ready=1 (once in IDLE), out_result=0, out_ovf=0, out_unf=0, and clear the internal man and exp registers.
REQ-030 Reset asserted during NORM or DONE SHALL abandon the operation; no output is produced for it.
REQ-031 After rst_n deasserts, the first accept is possible on the next rising edge.

Structure
REQ-032 Shared package fp_pkg SHALL hold:
 - EXP_W=8, MAN_W=23
 - EXP_MAX=8'hFF
 - FP_ZERO=32'h0
 - the state enum {IDLE, NORM, DONE}
REQ-033 One sub-module fp_pack SHALL be used: combinational {sign, exp, frac} to 32-bit packing with inf/zero override; all sequencing stays in the top.

Verification
REQ-034 Carry: exp=127, man=25'h100_0000 (1.0+1.0), sign 0 -> out_result=32'h4000_0000, flags 0, out_valid 2 cycles after accept.
REQ-035 Already normalized: exp=127, man=25'h080_0000 -> 32'h3F80_0000, latency 2.
REQ-036 Deep shift: exp=127, man=25'h000_0001 -> 32'h3400_0000 (exp 104), latency 25.
REQ-037 Overflow and underflow:
 - exp=254, man=25'h100_0000 -> 32'h7F80_0000, out_ovf=1.
 - exp=5, man=25'h000_0100 -> 32'h0000_0000, out_unf=1.
REQ-038 Backpressure and reset:
 - Hold out_ready=0 for 10 cycles in DONE -> out_result stable and in_ready=0 throughout.
 - Pulse rst_n low mid-NORM (from REQ-036) -> out_valid never rises; the next transaction completes correctly.
